// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a fetch port and a load/store port.
// One transaction in flight at a time; a watchdog aborts requests the memory never acknowledges.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch port
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_valid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,
  // load/store port
  input  logic                d_req,
  input  logic                d_we_re,
  input  logic [DATA_W/8-1:0] d_mask,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  // memory port
  output logic                mem_request,
  output logic                mem_we_re,
  output logic [DATA_W/8-1:0] mem_mask,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_valid
);

  localparam int unsigned MaskW = DATA_W / 8;
  localparam int unsigned WdW   = $clog2(TIMEOUT + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;     // 1 = load/store port owns the transaction
  logic              last_d_q, last_d_d;   // 1 = last grant went to the load/store port
  logic [WdW-1:0]    wd_q, wd_d;

  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [MaskW-1:0]  mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              i_valid_q, i_valid_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              i_err_q, i_err_d;
  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_err_q, d_err_d;

  logic              pick_dport;
  logic              resp_go;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d_d   = last_d_q;
    wd_d       = wd_q;
    req_d      = 1'b0;
    we_d       = we_q;
    mask_d     = mask_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    i_valid_d  = 1'b0;
    i_rdata_d  = i_rdata_q;
    i_err_d    = i_err_q;
    d_valid_d  = 1'b0;
    d_rdata_d  = d_rdata_q;
    d_err_d    = d_err_q;
    pick_dport = 1'b0;
    resp_go    = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_req || d_req) begin
          // On a tie the port that did not win last time gets the memory.
          pick_dport = d_req & (~i_req | ~last_d_q);
          owner_d    = pick_dport;
          last_d_d   = pick_dport;
          req_d      = 1'b1;
          state_d    = StIssue;
          if (pick_dport) begin
            we_d    = d_we_re;
            mask_d  = d_mask;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            we_d    = 1'b0;
            mask_d  = '1;
            addr_d  = i_addr;
            wdata_d = '0;
          end
        end
      end
      StIssue: begin
        state_d = StWait;
        wd_d    = WdW'(1);
      end
      StWait: begin
        // A completion on the last watchdog cycle still counts as a normal completion.
        if (mem_valid) begin
          resp_go    = 1'b1;
          resp_rdata = we_q ? '0 : mem_rdata;
        end else if (wd_q == WdW'(TIMEOUT - 1)) begin
          resp_go  = 1'b1;
          resp_err = 1'b1;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
        wd_d    = '0;
      end
      default: state_d = StIdle;
    endcase

    if (resp_go) begin
      state_d = StResp;
      if (owner_q) begin
        d_valid_d = 1'b1;
        d_rdata_d = resp_rdata;
        d_err_d   = resp_err;
      end else begin
        i_valid_d = 1'b1;
        i_rdata_d = resp_rdata;
        i_err_d   = resp_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      last_d_q  <= 1'b0;
      wd_q      <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      mask_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_valid_q <= 1'b0;
      i_rdata_q <= '0;
      i_err_q   <= 1'b0;
      d_valid_q <= 1'b0;
      d_rdata_q <= '0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_d_q  <= last_d_d;
      wd_q      <= wd_d;
      req_q     <= req_d;
      we_q      <= we_d;
      mask_q    <= mask_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_valid_q <= i_valid_d;
      i_rdata_q <= i_rdata_d;
      i_err_q   <= i_err_d;
      d_valid_q <= d_valid_d;
      d_rdata_q <= d_rdata_d;
      d_err_q   <= d_err_d;
    end
  end

  assign mem_request = req_q;
  assign mem_we_re   = we_q;
  assign mem_mask    = mask_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign i_valid     = i_valid_q;
  assign i_rdata     = i_rdata_q;
  assign i_err       = i_err_q;
  assign d_valid     = d_valid_q;
  assign d_rdata     = d_rdata_q;
  assign d_err       = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: behavioural memory responder plus a scoreboard of
// expected completions, all advanced cycle by cycle from one initial block.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  logic              clk;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_valid;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;
  logic              d_req;
  logic              d_we_re;
  logic [3:0]        d_mask;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;
  logic              mem_request;
  logic              mem_we_re;
  logic [3:0]        mem_mask;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;

  mem_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_valid    (i_valid),
    .i_rdata    (i_rdata),
    .i_err      (i_err),
    .d_req      (d_req),
    .d_we_re    (d_we_re),
    .d_mask     (d_mask),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_valid    (d_valid),
    .d_rdata    (d_rdata),
    .d_err      (d_err),
    .mem_request(mem_request),
    .mem_we_re  (mem_we_re),
    .mem_mask   (mem_mask),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_valid  (mem_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mem_arr [0:4095];

  // responder state: mem_delay = cycles from request to mem_valid, 0 = never answer
  int          mem_delay;
  bit          pend;
  int          left;
  bit          stray_en;
  logic [11:0] req_addr;
  int          req_cnt;
  logic        seen_we;
  logic [3:0]  seen_mask;
  logic [11:0] seen_addr;
  logic [31:0] seen_wdata;
  bit          saw_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_d, input logic [31:0] rdata, input bit err);
    exp_t e;
    e.is_d  = is_d;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  // One clock cycle: score completions, then drive the memory side for the next edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    saw_valid = i_valid | d_valid;
    if (i_valid) check("dual_valid", {31'd0, d_valid}, 32'd0);
    if (saw_valid) begin
      if (sb.size() == 0) begin
        check("stray_valid", {31'd0, saw_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("owner", {31'd0, d_valid}, {31'd0, e.is_d});
        if (e.is_d) begin
          check("d_rdata", d_rdata, e.rdata);
          check("d_err", {31'd0, d_err}, {31'd0, e.err});
        end else begin
          check("i_rdata", i_rdata, e.rdata);
          check("i_err", {31'd0, i_err}, {31'd0, e.err});
        end
      end
    end
    mem_valid = stray_en;
    mem_rdata = 32'hBAD0BAD0;
    if (mem_request) begin
      req_cnt++;
      pend       = 1'b1;
      left       = mem_delay;
      req_addr   = mem_addr;
      seen_we    = mem_we_re;
      seen_mask  = mem_mask;
      seen_addr  = mem_addr;
      seen_wdata = mem_wdata;
      if (mem_we_re) begin
        for (int b = 0; b < 4; b++)
          if (mem_mask[b]) mem_arr[mem_addr][b*8 +: 8] = mem_wdata[b*8 +: 8];
      end
    end else if (pend && mem_delay != 0) begin
      left--;
      if (left == 0) begin
        mem_valid = 1'b1;
        mem_rdata = mem_arr[req_addr];
        pend      = 1'b0;
      end
    end
  endtask

  task automatic wait_any(input int budget, output int cycles);
    bit got;
    got    = 1'b0;
    cycles = 0;
    while (!got && cycles < budget) begin
      tick();
      cycles++;
      got = saw_valid;
    end
    check("valid_within_budget", {31'd0, got}, 32'd1);
  endtask

  initial begin
    int cyc;
    int base;
    for (int a = 0; a < 4096; a++) mem_arr[a] = 32'hC0DE0000 | a;
    mem_arr[4] = 32'h00500093;
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we_re = 1'b0; d_mask = '0;
    d_addr = '0; d_wdata = '0; mem_valid = 1'b0; mem_rdata = '0; mem_delay = 1;
    pend = 1'b0; left = 0; stray_en = 1'b0; req_cnt = 0; saw_valid = 1'b0;
    repeat (3) tick();
    check("rst_mem_request", {31'd0, mem_request}, 32'd0);
    check("rst_mem_mask", {28'd0, mem_mask}, 32'd0);
    check("rst_i_valid", {31'd0, i_valid}, 32'd0);
    check("rst_d_valid", {31'd0, d_valid}, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // fetch only
    base = req_cnt;
    i_req = 1'b1; i_addr = 12'h004;
    push(1'b0, 32'h00500093, 1'b0);
    wait_any(10, cyc);
    check("fetch_latency", cyc, 32'd3);
    check("fetch_we", {31'd0, seen_we}, 32'd0);
    check("fetch_mask", {28'd0, seen_mask}, 32'hF);
    check("fetch_addr", {20'd0, seen_addr}, 32'h004);
    check("fetch_wdata", seen_wdata, 32'd0);
    check("fetch_req_pulses", req_cnt - base, 32'd1);
    i_req = 1'b0;
    tick();

    // store
    base = req_cnt;
    d_req = 1'b1; d_we_re = 1'b1; d_mask = 4'b0011; d_addr = 12'h010; d_wdata = 32'hDEADBEEF;
    push(1'b1, 32'd0, 1'b0);
    wait_any(10, cyc);
    check("store_latency", cyc, 32'd3);
    check("store_we", {31'd0, seen_we}, 32'd1);
    check("store_mask", {28'd0, seen_mask}, 32'h3);
    check("store_addr", {20'd0, seen_addr}, 32'h010);
    check("store_wdata", seen_wdata, 32'hDEADBEEF);
    check("store_req_pulses", req_cnt - base, 32'd1);
    d_req = 1'b0; d_we_re = 1'b0;
    tick();

    // contention from reset: D wins first, then strict alternation every 4 cycles
    rst = 1'b1;
    tick();
    i_req = 1'b1; i_addr = 12'h008;
    d_req = 1'b1; d_we_re = 1'b0; d_mask = 4'hF; d_addr = 12'h010; d_wdata = '0;
    push(1'b1, 32'hC0DEBEEF, 1'b0);
    push(1'b0, 32'hC0DE0008, 1'b0);
    push(1'b1, 32'hC0DEBEEF, 1'b0);
    push(1'b0, 32'hC0DE0008, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_any(10, cyc);
      check("contention_gap", cyc, (k == 0) ? 32'd3 : 32'd4);
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
    check("sb_drained_contention", sb.size(), 32'd0);

    // timeout, then a normal fetch
    mem_delay = 0;
    i_req = 1'b1; i_addr = 12'h030;
    push(1'b0, 32'd0, 1'b1);
    wait_any(40, cyc);
    check("timeout_latency", cyc, 32'd1 + TIMEOUT);
    i_req = 1'b0;
    tick();
    pend = 1'b0; mem_delay = 1;
    i_req = 1'b1; i_addr = 12'h004;
    push(1'b0, 32'h00500093, 1'b0);
    wait_any(10, cyc);
    check("after_timeout_latency", cyc, 32'd3);
    i_req = 1'b0;
    tick();

    // late memory completion, then stray mem_valid while idle
    mem_delay = 5;
    i_req = 1'b1; i_addr = 12'h008;
    push(1'b0, 32'hC0DE0008, 1'b0);
    wait_any(20, cyc);
    check("late_latency", cyc, 32'd7);
    i_req = 1'b0;
    tick();
    stray_en = 1'b1;
    repeat (6) tick();
    stray_en = 1'b0;
    tick();
    check("i_rdata_hold", i_rdata, 32'hC0DE0008);
    check("i_err_hold", {31'd0, i_err}, 32'd0);

    // reset in the middle of WAIT discards the transaction
    mem_delay = 0;
    d_req = 1'b1; d_we_re = 1'b1; d_mask = 4'hF; d_addr = 12'h040; d_wdata = 32'h12345678;
    repeat (3) tick();
    check("midwait_we_before_rst", {31'd0, mem_we_re}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_mem_request", {31'd0, mem_request}, 32'd0);
    check("midrst_mem_we", {31'd0, mem_we_re}, 32'd0);
    check("midrst_mem_mask", {28'd0, mem_mask}, 32'd0);
    check("midrst_mem_addr", {20'd0, mem_addr}, 32'd0);
    check("midrst_mem_wdata", mem_wdata, 32'd0);
    check("midrst_i_valid", {31'd0, i_valid}, 32'd0);
    check("midrst_d_valid", {31'd0, d_valid}, 32'd0);
    check("midrst_i_rdata", i_rdata, 32'd0);
    check("midrst_d_rdata", d_rdata, 32'd0);
    check("midrst_i_err", {31'd0, i_err}, 32'd0);
    check("midrst_d_err", {31'd0, d_err}, 32'd0);
    pend = 1'b0;
    d_req = 1'b0; d_we_re = 1'b0;
    tick();
    rst = 1'b0;
    mem_delay = 1;
    repeat (12) tick();
    check("sb_drained_final", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
